btn_irq_ctrl: RTL and testbench

- Input stage between the board pushbuttons (DIR_RIGHT/DIR_DOWN/DIR_LEFT) and the pacoblaze3 core inside the bamse SoC.
- Synchronises and debounces each button, latches rising edges into a pending register, and drives the core's interrupt/interrupt_ack handshake.
- Exposes pending, level and mask on the core's port bus, next to the existing ports block.

---
 rtl/btn_irq_ctrl.sv | 118 +++++++++++
 tb/tb_btn_irq_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_irq_ctrl.sv
// Pushbutton input stage for the pacoblaze3 core: synchronise, debounce,
// latch rising edges into pending, and run the interrupt/ack handshake.
module btn_irq_ctrl #(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 20,
  parameter logic [7:0]  PORT_STATUS     = 8'h10,
  parameter logic [7:0]  PORT_MASK       = 8'h11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [7:0]       port_id,
  input  logic             write_strobe,
  input  logic             read_strobe,
  input  logic [7:0]       out_port,
  output logic [7:0]       in_port,
  output logic             interrupt,
  input  logic             interrupt_ack,
  output logic [N_BTN-1:0] btn_level
);

  // A new level is accepted once the counter has seen it differ for the full
  // debounce window, giving level at edge 2+DEBOUNCE_CYCLES after an input change.
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] level_q;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] mask;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] clr;
  logic             req;
  logic [1:0]       state;
  logic [1:0]       next_state;
  logic             unused_bits;

  assign unused_bits = ^{read_strobe, out_port[7:N_BTN]};

  // Two-flop synchroniser followed by a per-bit debounce counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      btn_level <= '0;
      level_q   <= '0;
      for (int i = 0; i < int'(N_BTN); i++) cnt[i] <= '0;
    end else begin
      sync1   <= btn_in;
      sync2   <= sync1;
      level_q <= btn_level;
      for (int i = 0; i < int'(N_BTN); i++) begin
        if (sync2[i] == btn_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_DONE) begin
          btn_level[i] <= sync2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise = btn_level & ~level_q;
  assign clr  = (write_strobe && (port_id == PORT_STATUS)) ? out_port[N_BTN-1:0] : '0;
  assign req  = |(pending & mask);

  // Pending (set on rising level, write-1-to-clear, set wins) and mask register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
      mask    <= '1;
    end else begin
      pending <= (pending & ~clr) | rise;
      if (write_strobe && (port_id == PORT_MASK)) mask <= out_port[N_BTN-1:0];
    end
  end

  // Handshake state register; interrupt is a registered decode of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      interrupt <= 1'b0;
    end else begin
      state     <= next_state;
      interrupt <= (next_state == ST_REQ);
    end
  end

  // Next-state logic: request held until ack, no re-request until req drops.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (req) next_state = ST_REQ;
      ST_REQ:     if (interrupt_ack) next_state = ST_SERVICE;
      ST_SERVICE: if (!req) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Read mux on port_id.
  always_comb begin
    in_port = 8'h00;
    if (port_id == PORT_STATUS) begin
      in_port = {1'b0, 3'(btn_level), 1'b0, 3'(pending)};
    end else if (port_id == PORT_MASK) begin
      in_port = 8'(mask);
    end
  end

endmodule

// File: tb/tb_btn_irq_ctrl.sv
// Directed bench for btn_irq_ctrl with default parameters.
module tb_btn_irq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] btn_in;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;
  logic [2:0] btn_level;

  int errors;
  int checks;

  btn_irq_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .out_port      (out_port),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .btn_level     (btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge, land on the following falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic port_write(input logic [7:0] addr, input logic [7:0] data);
    port_id      = addr;
    out_port     = data;
    write_strobe = 1'b1;
    step(1);
    write_strobe = 1'b0;
    out_port     = 8'h00;
  endtask

  task automatic pulse_ack();
    interrupt_ack = 1'b1;
    step(1);
    interrupt_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_in = 3'b111;
    step(2);
    checks++; if (btn_level !== 3'b000) begin errors++; $display("FAIL reset_level got=%b exp=000", btn_level); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", interrupt); end
    port_id = 8'h11; #1;
    checks++; if (in_port !== 8'h07) begin errors++; $display("FAIL reset_mask got=%h exp=07", in_port); end
    port_id = 8'h10; #1;
    checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL reset_status got=%h exp=00", in_port); end
    btn_in = 3'b000;
    step(1);
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_clean_press();
    btn_in = 3'b001;
    step(18);
    checks++; if (btn_level !== 3'b000) begin errors++; $display("FAIL press_level_e17 got=%b exp=000", btn_level); end
    step(1);
    checks++; if (btn_level !== 3'b001) begin errors++; $display("FAIL press_level_e18 got=%b exp=001", btn_level); end
    port_id = 8'h10; #1;
    checks++; if (in_port !== 8'h10) begin errors++; $display("FAIL press_status_e18 got=%h exp=10", in_port); end
    step(1);
    port_id = 8'h10; #1;
    checks++; if (in_port !== 8'h11) begin errors++; $display("FAIL press_pending_e19 got=%h exp=11", in_port); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL press_irq_e19 got=%b exp=0", interrupt); end
    step(1);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL press_irq_e20 got=%b exp=1", interrupt); end
    step(20);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL press_irq_held got=%b exp=1", interrupt); end
  endtask

  task automatic test_handshake();
    pulse_ack();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL hs_ack_drop got=%b exp=0", interrupt); end
    step(3);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL hs_service_quiet got=%b exp=0", interrupt); end
    port_id = 8'h10; #1;
    checks++; if (in_port !== 8'h11) begin errors++; $display("FAIL hs_status_service got=%h exp=11", in_port); end
    port_write(8'h10, 8'h01);
    port_id = 8'h10; #1;
    checks++; if (in_port !== 8'h10) begin errors++; $display("FAIL hs_w1c got=%h exp=10", in_port); end
    step(2);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL hs_idle got=%b exp=0", interrupt); end
    btn_in = 3'b000;
    step(25);
    port_id = 8'h10; #1;
    checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL hs_release got=%h exp=00", in_port); end
    btn_in = 3'b001;
    step(20);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL hs_second_e19 got=%b exp=0", interrupt); end
    step(1);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL hs_second_e20 got=%b exp=1", interrupt); end
    pulse_ack();
    port_write(8'h10, 8'h01);
    btn_in = 3'b000;
    step(25);
    port_id = 8'h10; #1;
    checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL hs_final_status got=%h exp=00", in_port); end
  endtask

  task automatic test_glitch();
    btn_in = 3'b010;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) btn_in = 3'b000;
      step(1);
      checks++;
      if (btn_level !== 3'b000 || interrupt !== 1'b0) begin
        errors++;
        $display("FAIL glitch_step%0d level=%b irq=%b exp level=000 irq=0", i, btn_level, interrupt);
      end
    end
    port_id = 8'h10; #1;
    checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL glitch_status got=%h exp=00", in_port); end
  endtask

  task automatic test_mask_collision();
    port_write(8'h11, 8'h04);
    port_id = 8'h11; #1;
    checks++; if (in_port !== 8'h04) begin errors++; $display("FAIL mask_read got=%h exp=04", in_port); end
    btn_in = 3'b010;
    step(25);
    port_id = 8'h10; #1;
    checks++; if (in_port !== 8'h22) begin errors++; $display("FAIL mask_pending got=%h exp=22", in_port); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL mask_blocked got=%b exp=0", interrupt); end
    btn_in = 3'b110;
    step(20);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL mask_btn2_e19 got=%b exp=0", interrupt); end
    step(1);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL mask_btn2_e20 got=%b exp=1", interrupt); end
    port_id = 8'h10; #1;
    checks++; if (in_port !== 8'h66) begin errors++; $display("FAIL mask_status got=%h exp=66", in_port); end
    pulse_ack();
    btn_in = 3'b010;
    step(25);
    port_id = 8'h10; #1;
    checks++; if (in_port !== 8'h26) begin errors++; $display("FAIL coll_pre got=%h exp=26", in_port); end
    btn_in = 3'b110;
    step(19);
    port_write(8'h10, 8'h04);
    port_id = 8'h10; #1;
    checks++; if (in_port !== 8'h66) begin errors++; $display("FAIL coll_set_wins got=%h exp=66", in_port); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL coll_no_rereq got=%b exp=0", interrupt); end
    port_write(8'h10, 8'h04);
    port_id = 8'h10; #1;
    checks++; if (in_port !== 8'h62) begin errors++; $display("FAIL coll_w1c got=%h exp=62", in_port); end
    step(1);
    port_write(8'h11, 8'h07);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL unmask_e0 got=%b exp=0", interrupt); end
    step(1);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL unmask_e1 got=%b exp=1", interrupt); end
    pulse_ack();
    port_write(8'h10, 8'hFF);
    btn_in = 3'b000;
    step(25);
    port_id = 8'h10; #1;
    checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL mask_final got=%h exp=00", in_port); end
  endtask

  task automatic test_reset_mid_service();
    btn_in = 3'b001;
    step(21);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL rms_req got=%b exp=1", interrupt); end
    pulse_ack();
    port_id = 8'h10; #1;
    checks++; if (in_port !== 8'h11) begin errors++; $display("FAIL rms_service_status got=%h exp=11", in_port); end
    rst_n = 1'b0;
    step(1);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rms_irq got=%b exp=0", interrupt); end
    port_id = 8'h10; #1;
    checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL rms_status got=%h exp=00", in_port); end
    rst_n = 1'b1;
    step(20);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rms_e19 got=%b exp=0", interrupt); end
    step(1);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL rms_e20 got=%b exp=1", interrupt); end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    btn_in        = 3'b000;
    port_id       = 8'h00;
    write_strobe  = 1'b0;
    read_strobe   = 1'b0;
    out_port      = 8'h00;
    interrupt_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_handshake();
    test_glitch();
    test_mask_collision();
    test_reset_mid_service();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
